cca_ch_idle: RTL

CCA_CH_IDLE -- requirements
Module: cca_ch_idle

---
 rtl/cca_ch_idle_pkg.sv | 15 +
 rtl/cca_ch_idle_us_down_counter.sv | 38 +++
 rtl/cca_ch_idle.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cca_ch_idle_pkg.sv
// Shared definitions for the CCA channel-idle detector: state encoding and
// default parameter widths.
package cca_ch_idle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_IDLE_WAIT = 2'd2,
        ST_TX_HOLD   = 2'd3
    } cca_state_e;

    localparam int CCA_TIMER_WIDTH_DEF = 12;
    localparam int CCA_RSSI_WIDTH_DEF  = 11;

endpackage : cca_ch_idle_pkg

// File: rtl/cca_ch_idle_us_down_counter.sv
// Microsecond hold timer: loadable down-counter that decrements on an enabled
// tick, sticks at zero and flags terminal count.
module cca_us_down_counter
    import cca_ch_idle_pkg::*;
#(
    parameter int WIDTH = CCA_TIMER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && !zero) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : cca_us_down_counter

// File: rtl/cca_ch_idle.sv
// Clear-channel assessment: combines RSSI energy, demodulator and own-TX activity
// into a debounced ch_idle flag. Define CCA_BUSY_STAT_EN to build the busy-time counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | channel quiet, ch_idle asserted
// BUSY       | energy or packet present on air
// IDLE_WAIT  | energy gone, waiting idle_debounce_time before declaring idle
// TX_HOLD    | own TX active or within tx_holdoff_time after it ended
module cca_ch_idle
    import cca_ch_idle_pkg::*;
#(
    parameter int RSSI_HALF_DB_WIDTH = CCA_RSSI_WIDTH_DEF,
    parameter int TIMER_WIDTH        = CCA_TIMER_WIDTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 tsf_pulse_1M,
    input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
    input  logic                                 rssi_valid,
    input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_th,
    input  logic                                 demod_busy,
    input  logic                                 tx_busy,
    input  logic [TIMER_WIDTH-1:0]               idle_debounce_time,
    input  logic [TIMER_WIDTH-1:0]               tx_holdoff_time,
    input  logic                                 stat_clear,
    output logic                                 ch_idle,
    output logic [1:0]                           cca_state,
    output logic [31:0]                          busy_us_count
);

    cca_state_e             state_q, state_d;
    logic                   rssi_above_q, rssi_above_d;
    logic                   ch_idle_q, ch_idle_d;
    logic                   energy_busy;
    logic                   hold_load;
    logic [TIMER_WIDTH-1:0] hold_load_val;
    logic                   hold_dec_en;
    logic                   hold_zero;

    always_comb begin
        rssi_above_d = rssi_above_q;
        if (rssi_valid) begin
            rssi_above_d = ($signed(rssi_half_db) > $signed(rssi_th));
        end
    end

    assign energy_busy = rssi_above_q | demod_busy;

    always_comb begin
        state_d       = state_q;
        hold_load     = 1'b0;
        hold_load_val = idle_debounce_time;
        hold_dec_en   = 1'b0;

        if (tx_busy) begin
            state_d       = ST_TX_HOLD;
            hold_load     = 1'b1;
            hold_load_val = tx_holdoff_time;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (energy_busy) state_d = ST_BUSY;
                end
                ST_BUSY: begin
                    if (!energy_busy) begin
                        state_d   = ST_IDLE_WAIT;
                        hold_load = 1'b1;
                    end
                end
                ST_IDLE_WAIT: begin
                    if (energy_busy) begin
                        state_d = ST_BUSY;
                    end else if (hold_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_dec_en = 1'b1;
                    end
                end
                ST_TX_HOLD: begin
                    if (!hold_zero) begin
                        hold_dec_en = 1'b1;
                    end else if (energy_busy) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d   = ST_IDLE_WAIT;
                        hold_load = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ch_idle decodes the registered state, so it trails the state change by one clk.
    assign ch_idle_d = (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            rssi_above_q <= 1'b0;
            ch_idle_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            rssi_above_q <= rssi_above_d;
            ch_idle_q    <= ch_idle_d;
        end
    end

    cca_us_down_counter #(
        .WIDTH (TIMER_WIDTH)
    ) u_hold_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (hold_load),
        .load_val (hold_load_val),
        .tick     (hold_dec_en & tsf_pulse_1M),
        .zero     (hold_zero)
    );

    assign ch_idle   = ch_idle_q;
    assign cca_state = state_q;

`ifdef CCA_BUSY_STAT_EN
    logic [31:0] busy_cnt_q, busy_cnt_d;

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (stat_clear) begin
            busy_cnt_d = '0;
        end else if (tsf_pulse_1M && !ch_idle_q && (busy_cnt_q != '1)) begin
            busy_cnt_d = busy_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_us_count = busy_cnt_q;
`else
    logic stat_clear_unused;
    assign stat_clear_unused = stat_clear;
    assign busy_us_count     = '0;
`endif

endmodule : cca_ch_idle
